// File: rtl/lstm_train_sequencer_if.sv
// lstm_train_sequencer_if
// Groups the controller-side handshake, the run programming inputs and the
// LSTM array control outputs of lstm_train_sequencer.
//   start, abort          : run request / run termination (controller -> sequencer)
//   num_iter, compute_len : run programming, latched on accepted start
//   pause                 : COMPUTE hold, only with LSTM_SEQ_PAUSE_EN defined
//   busy, done            : run status back to the controller
//   arr_rst, load, sel    : LSTM array reset, weight-load strobe, weight source
//   iter, phase_cnt       : current round index and compute-phase cycle count
// modport master: training controller side; modport slave: the sequencer.
interface lstm_train_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_iter;
    logic [CNT_W-1:0] compute_len;
`ifdef LSTM_SEQ_PAUSE_EN
    logic             pause;
`endif
    logic             busy;
    logic             done;
    logic             arr_rst;
    logic             load;
    logic             sel;
    logic [CNT_W-1:0] iter;
    logic [CNT_W-1:0] phase_cnt;

    modport master (
        output start, abort, num_iter, compute_len,
`ifdef LSTM_SEQ_PAUSE_EN
        output pause,
`endif
        input  busy, done, arr_rst, load, sel, iter, phase_cnt
    );

    modport slave (
        input  start, abort, num_iter, compute_len,
`ifdef LSTM_SEQ_PAUSE_EN
        input  pause,
`endif
        output busy, done, arr_rst, load, sel, iter, phase_cnt
    );
endinterface

// File: rtl/lstm_train_sequencer.sv
// lstm_train_sequencer
// Generates the reset / compute / weight-load / select pattern for the LSTM
// array over a programmable number of training rounds. Round 0 loads initial
// weights (sel=0), later rounds load back-propagated weights (sel=1).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : lstm_train_sequencer_if.slave (start/abort/num_iter/compute_len in,
//         busy/done/arr_rst/load/sel/iter/phase_cnt out)
// Optional feature: define LSTM_SEQ_PAUSE_EN to add bus.pause, which freezes
// the COMPUTE phase while high.
// All outputs are registered: next-state logic also produces next output
// values, so every output changes only at a clock edge (or on reset).
module lstm_train_sequencer #(
    parameter int CNT_W        = 16,
    parameter int DEF_COMPUTE  = 44,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    lstm_train_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clr_q, clr_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] niter_q, niter_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             arr_rst_q, arr_rst_d;
    logic             load_q, load_d;
    logic             sel_q, sel_d;
    logic             pause_w;

`ifdef LSTM_SEQ_PAUSE_EN
    assign pause_w = bus.pause;
`else
    assign pause_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        phase_d = phase_q;
        iter_d  = iter_q;
        niter_d = niter_q;
        len_d   = len_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_CLEAR;
                    niter_d = bus.num_iter;
                    len_d   = (bus.compute_len == '0) ? CNT_W'(DEF_COMPUTE)
                                                      : bus.compute_len;
                    iter_d  = '0;
                    clr_d   = '0;
                    phase_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_q == CNT_W'(CLEAR_CYCLES - 1)) begin
                    state_d = (niter_q != '0) ? S_COMPUTE : S_DONE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (!pause_w) begin
                    if (phase_q == len_q - 1'b1) begin
                        state_d = S_LOAD;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (iter_q == niter_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every in-run transition, including a paused COMPUTE.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
        end

        if (state_d == S_IDLE) begin
            iter_d  = '0;
            phase_d = '0;
        end

        // Registered Moore outputs are decoded from the state being entered.
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        arr_rst_d = (state_d == S_CLEAR);
        load_d    = (state_d == S_LOAD);
        sel_d     = (state_d == S_LOAD) && (iter_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clr_q     <= '0;
            phase_q   <= '0;
            iter_q    <= '0;
            niter_q   <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arr_rst_q <= 1'b0;
            load_q    <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            phase_q   <= phase_d;
            iter_q    <= iter_d;
            niter_q   <= niter_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            arr_rst_q <= arr_rst_d;
            load_q    <= load_d;
            sel_q     <= sel_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.arr_rst   = arr_rst_q;
    assign bus.load      = load_q;
    assign bus.sel       = sel_q;
    assign bus.iter      = iter_q;
    assign bus.phase_cnt = phase_q;

endmodule

// File: doc/lstm_train_sequencer.md
Name: lstm_train_sequencer

Overview:
- Parametrised control sequencer that generates the reset / compute / weight-load / select pattern for the LSTM array across a programmable number of training rounds.
- Replaces the hand-timed stimulus used to step the array today.
- Sits between the top-level training controller (start/done handshake) and the LSTM array's `rst`, `load` and `sel` inputs.
- Round 0 loads initial weights (`sel=0`); every later round loads back-propagated weights (`sel=1`).

Parameters:
- CNT_W, 16: width of the round and cycle counters and of the programming inputs.
- DEF_COMPUTE, 44: compute-phase length used when `compute_len` is 0.
- CLEAR_CYCLES, 1: number of cycles `arr_rst` is held high at the start of a run (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  terminate the current run.
- num_iter  in  CNT_W  number of load rounds; latched on accepted start.
- compute_len  in  CNT_W  cycles per compute phase; latched on accepted start; 0 selects DEF_COMPUTE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- arr_rst  out  1  active-high reset to the LSTM array.
- load  out  1  one-cycle weight-load strobe to the array.
- sel  out  1  weight-source select; 0 = initial, 1 = updated; valid while `load` is high.
- iter  out  CNT_W  current round index, 0-based.
- phase_cnt  out  CNT_W  cycles elapsed in the current COMPUTE phase.

Behaviour:
- All outputs are registered (Moore).
- Reset (`rst`=0, asynchronous) forces state IDLE and drives every output to 0. Reset asserted mid-run aborts immediately; no `done` pulse follows.
- States: IDLE → CLEAR → COMPUTE ↔ LOAD → DONE → IDLE.
- IDLE: `busy`=0. `start`=1 and `abort`=0 at an edge latches `num_iter` and the effective compute length, clears `iter`, and enters CLEAR.
- CLEAR:
  - `arr_rst`=1 for CLEAR_CYCLES cycles.
  - Then enters COMPUTE if latched `num_iter` ≠ 0; otherwise enters DONE (no load ever issued).
- COMPUTE:
  - `phase_cnt` counts 0..L-1, where L is the effective compute length.
  - After L cycles, enters LOAD; `phase_cnt` returns to 0.
- LOAD: one cycle, `load`=1, `sel`=(`iter`≠0).
  - If `iter`=`num_iter`-1, enters DONE.
  - Otherwise `iter` increments and the block re-enters COMPUTE.
- DONE: one cycle, `done`=1, `busy`=1. Then enters IDLE.
- Latency: the first cycle after the accepted start edge is CLEAR. `done` is high in cycle CLEAR_CYCLES + num_iter·(L+1) + 1 after that edge.
- Busy handling: `start` is ignored while `busy`=1. `num_iter`/`compute_len` changes mid-run have no effect.
- Abort:
  - `abort`=1 in any non-IDLE state returns to IDLE at the next edge.
  - `load`, `sel`, `arr_rst` and `done` are all 0 from that edge.
  - `abort` and `start` together in IDLE: start is ignored.
  - Abort during DONE: the pulse still completes that cycle.
- Wrap-around: counters never wrap. `iter` saturates by construction at `num_iter`-1; L is at most 2^CNT_W-1.
- Outputs are idle-valued (0) in states where not stated otherwise.

Optional Feature:
- Macro: LSTM_SEQ_PAUSE_EN.
- With the macro defined:
  - Extra input `pause` (1 bit) is added.
  - While `pause`=1 in COMPUTE, `phase_cnt` holds and the LOAD transition is blocked. The exit from COMPUTE is delayed one cycle per paused cycle.
  - `pause` is ignored in all other states.
  - `abort` overrides `pause`.
- Without the macro: no `pause` port exists and COMPUTE always advances.

Test Plan:
- Reset: hold `rst`=0 with `start`=1 → all outputs 0. Release `rst`, pulse `start` with `num_iter`=3, `compute_len`=4 (CLEAR_CYCLES=1) → `arr_rst` high in cycle 1; `load` high in cycles 6, 11 and 16 with `sel`=0, 1, 1; `iter`=0, 1, 2 at those loads; `done` high in cycle 17 only.
- Default length: `num_iter`=1, `compute_len`=0 → `load` high in cycle 46, `done` high in cycle 47.
- Zero rounds: `num_iter`=0 → `arr_rst` high in cycle 1, `done` high in cycle 2, `load` never asserted.
- Abort: `num_iter`=3, `compute_len`=4; assert `abort` in cycle 8 → `busy`=0 from cycle 9; no further `load`; no `done`. A new `start` is accepted immediately afterwards.
- Start while busy and async reset:
  - Pulse `start` during cycle 3 of a run → ignored; timing is identical to the first scenario.
  - Drop `rst` asynchronously in cycle 10 → outputs are 0 without waiting for a clock edge.
- With LSTM_SEQ_PAUSE_EN, first-scenario setup: hold `pause` high in cycles 3–5 → first `load` moves to cycle 9 and `done` to cycle 20.
